// File: rtl/sparse_fm_pkg.sv
// Shared constants, FSM encoding and bit-counting helpers for the sparse
// feature-map decoder.
package sparse_fm_pkg;

    localparam int ELEMS_PER_WORD  = 16;
    localparam int SLICES_PER_MASK = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of set bits in a 16-bit mask slice (0..16).
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

    // Number of set bits strictly below position j; this is the index of
    // element j's value inside the packed nonzero stream of its slice.
    function automatic logic [3:0] prefix_rank(input logic [15:0] v, input int j);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < j) begin
                r = r + {3'b000, v[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sparse_fm_decoder_expand.sv
// Combinational expansion of one 16-bit mask slice against the lowest
// 16 bytes of the encoded buffer into one dense word.
module sparse_slice_expand
    import sparse_fm_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic [15:0]                  slice_i,
    input  logic [ELEMS_PER_WORD*EW-1:0] window_i,
    output logic [ELEMS_PER_WORD*EW-1:0] dense_o,
    output logic [4:0]                   pop_o
);

    // Scatter packed values to the positions of the set mask bits.
    always_comb begin
        dense_o = '0;
        for (int j = 0; j < ELEMS_PER_WORD; j++) begin
            if (slice_i[j]) begin
                dense_o[EW*j +: EW] = window_i[EW*prefix_rank(slice_i, j) +: EW];
            end
        end
    end

    assign pop_o = popcount16(slice_i);

endmodule

// File: rtl/sparse_fm_decoder.sv
// Sparse feature-map decoder: rebuilds dense activation words from the
// bitmask stream and the packed nonzero-value stream.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; output valid/data are registered and held until accepted, and
// out_dense_valid never depends combinationally on out_dense_ready.
module sparse_fm_decoder
    import sparse_fm_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 8,
    parameter int MEM_BW             = 128,
    parameter int FEATURE_MAP_WIDTH  = 56,
    parameter int FEATURE_MAP_HEIGHT = 56,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int FRAME_MASK_WORDS   =
        FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS / MEM_BW
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              start,
    output logic              busy,
    input  logic [MEM_BW-1:0] in_masks,
    input  logic              in_masks_valid,
    output logic              in_masks_ready,
    input  logic [MEM_BW-1:0] in_encoded,
    input  logic              in_encoded_valid,
    output logic              in_encoded_ready,
    output logic [MEM_BW-1:0] out_dense,
    output logic              out_dense_valid,
    input  logic              out_dense_ready,
    output logic              out_dense_last,
    output logic              overflow_error
);

    localparam int WORDS = SLICES_PER_MASK * FRAME_MASK_WORDS;
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int BUF_W = 2 * MEM_BW;

    state_e              state_q, state_d;
    logic [MEM_BW-1:0]   mask_q, mask_d;
    logic                mask_full_q, mask_full_d;
    logic [2:0]          slice_q, slice_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [MEM_BW-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [WCW-1:0]      word_cnt_q, word_cnt_d;
    logic                overflow_q, overflow_d;

    logic                run;
    logic                out_fire, out_free, frame_open, frame_end;
    logic                produce, mask_ready, enc_ready, mask_fire, enc_fire;
    logic [15:0]         slice_bits;
    logic [MEM_BW-1:0]   dense_w;
    logic [4:0]          pop_w, pop_eff;
    logic [5:0]          cnt_after;
    logic [BUF_W-1:0]    buf_shift;

    assign slice_bits = mask_q[{slice_q, 4'b0000} +: 16];

    sparse_slice_expand #(
        .EW(IO_DATA_WIDTH)
    ) u_expand (
        .slice_i (slice_bits),
        .window_i(buf_q[MEM_BW-1:0]),
        .dense_o (dense_w),
        .pop_o   (pop_w)
    );

    // Handshake and produce qualification shared by FSM and datapath.
    always_comb begin
        run        = (state_q == ST_RUN);
        out_fire   = out_valid_q && out_dense_ready;
        out_free   = !out_valid_q || out_dense_ready;
        frame_open = (word_cnt_q != WCW'(WORDS));
        frame_end  = run && out_fire && out_last_q;
        produce    = run && mask_full_q && frame_open &&
                     (cnt_q >= {1'b0, pop_w}) && out_free;
        pop_eff    = produce ? pop_w : 5'd0;
        mask_ready = run && (!mask_full_q || (produce && (slice_q == 3'd7)));
        enc_ready  = run && (cnt_q <= 6'd16);
        mask_fire  = in_masks_valid && mask_ready;
        enc_fire   = in_encoded_valid && enc_ready;
        cnt_after  = cnt_q - {1'b0, pop_eff};
        buf_shift  = buf_q >> {pop_eff, 3'b000};
    end

    // FSM next state: a frame runs from start until the last dense handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (frame_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state: mask slices, encoded byte buffer, output register.
    always_comb begin
        mask_d      = mask_q;
        mask_full_d = mask_full_q;
        slice_d     = slice_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;
        overflow_d  = overflow_q;

        if (state_q == ST_IDLE) begin
            if (start) begin
                mask_full_d = 1'b0;
                slice_d     = '0;
                buf_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                word_cnt_d  = '0;
                overflow_d  = 1'b0;
            end
        end else begin
            // The source cannot stall, so any refused valid is lost data.
            if ((in_masks_valid && !mask_ready) || (in_encoded_valid && !enc_ready)) begin
                overflow_d = 1'b1;
            end

            if (mask_fire) begin
                mask_d      = in_masks;
                mask_full_d = 1'b1;
                slice_d     = '0;
            end else if (produce) begin
                if (slice_q == 3'd7) begin
                    mask_full_d = 1'b0;
                    slice_d     = '0;
                end else begin
                    slice_d = slice_q + 3'd1;
                end
            end

            // Bytes above cnt are always zero, so an OR appends cleanly.
            if (enc_fire) begin
                buf_d = buf_shift | ({{MEM_BW{1'b0}}, in_encoded} << {cnt_after, 3'b000});
                cnt_d = cnt_after + 6'd16;
            end else begin
                buf_d = buf_shift;
                cnt_d = cnt_after;
            end

            if (produce) begin
                out_data_d  = dense_w;
                out_valid_d = 1'b1;
                out_last_d  = (word_cnt_q == WCW'(WORDS - 1));
                word_cnt_d  = word_cnt_q + WCW'(1);
            end else if (out_fire) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end

            // Residual bytes after the last word are encoder padding.
            if (frame_end) begin
                buf_d = '0;
                cnt_d = '0;
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            mask_full_q <= 1'b0;
            slice_q     <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mask_full_q <= mask_full_d;
            slice_q     <= slice_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy             = run;
    assign in_masks_ready   = mask_ready;
    assign in_encoded_ready = enc_ready;
    assign out_dense        = out_data_q;
    assign out_dense_valid  = out_valid_q;
    assign out_dense_last   = out_last_q;
    assign overflow_error   = overflow_q;

endmodule

// File: tb/tb_sparse_fm_decoder.sv
// Self-checking bench for sparse_fm_decoder with a two-mask-word frame.
module tb_sparse_fm_decoder;

    localparam int MW    = 2;
    localparam int WORDS = 8 * MW;

    logic         clk;
    logic         arst_n_in;
    logic         start;
    logic         busy;
    logic [127:0] in_masks;
    logic         in_masks_valid;
    logic         in_masks_ready;
    logic [127:0] in_encoded;
    logic         in_encoded_valid;
    logic         in_encoded_ready;
    logic [127:0] out_dense;
    logic         out_dense_valid;
    logic         out_dense_ready;
    logic         out_dense_last;
    logic         overflow_error;

    int checks = 0;
    int errors = 0;

    logic [127:0] masks [MW];
    logic [7:0]   vals [$];
    logic [127:0] exp_q [$];
    logic [127:0] enc_words [$];
    logic [127:0] first_word, second_word;

    sparse_fm_decoder #(
        .FRAME_MASK_WORDS(MW)
    ) u_dut (
        .clk             (clk),
        .arst_n_in       (arst_n_in),
        .start           (start),
        .busy            (busy),
        .in_masks        (in_masks),
        .in_masks_valid  (in_masks_valid),
        .in_masks_ready  (in_masks_ready),
        .in_encoded      (in_encoded),
        .in_encoded_valid(in_encoded_valid),
        .in_encoded_ready(in_encoded_ready),
        .out_dense       (out_dense),
        .out_dense_valid (out_dense_valid),
        .out_dense_ready (out_dense_ready),
        .out_dense_last  (out_dense_last),
        .overflow_error  (overflow_error)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        arst_n_in        = 1'b0;
        start            = 1'b0;
        in_masks         = '0;
        in_masks_valid   = 1'b0;
        in_encoded       = '0;
        in_encoded_valid = 1'b0;
        out_dense_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n_in = 1'b1;
    endtask

    // Reference model: walk elements in frame order, each set mask bit takes
    // the next value of the nonzero stream; encoded words are the stream cut
    // into 16-byte groups with random padding at the tail.
    task automatic build_model();
        int idx;
        int nw;
        logic [127:0] w;
        exp_q.delete();
        enc_words.delete();
        idx = 0;
        for (int m = 0; m < MW; m++) begin
            for (int s = 0; s < 8; s++) begin
                w = '0;
                for (int j = 0; j < 16; j++) begin
                    if (masks[m][16*s + j]) begin
                        w[8*j +: 8] = vals[idx];
                        idx++;
                    end
                end
                exp_q.push_back(w);
            end
        end
        nw = (vals.size() + 15) / 16;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int b = 0; b < 16; b++) begin
                if (16*k + b < vals.size()) w[8*b +: 8] = vals[16*k + b];
                else                        w[8*b +: 8] = 8'($urandom_range(0, 255));
            end
            enc_words.push_back(w);
        end
    endtask

    task automatic random_frame(input int density);
        vals.delete();
        for (int m = 0; m < MW; m++) begin
            for (int b = 0; b < 128; b++) begin
                masks[m][b] = ($urandom_range(0, 99) < density);
                if (masks[m][b]) vals.push_back(8'($urandom_range(1, 255)));
            end
        end
    endtask

    // Drives one frame. mode 0: always ready; 1: one 5-cycle stall; 2: random ready.
    task automatic run_frame(input int mode, input string name);
        int mi, ei, out_n, cyc, stall_cnt;
        bit done, hold_pend;
        logic [127:0] held, e;
        build_model();
        mi = 0; ei = 0; out_n = 0; cyc = 0; stall_cnt = 0;
        done = 1'b0; hold_pend = 1'b0; held = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b need 1", name, busy);
        end
        while (!done && cyc < 2000) begin
            if (hold_pend) begin
                checks++;
                if (out_dense_valid !== 1'b1 || out_dense !== held) begin
                    errors++;
                    $display("FAIL %s hold_stable: got v=%b %h need v=1 %h",
                             name, out_dense_valid, out_dense, held);
                end
            end
            case (mode)
                1: begin
                    if (out_n >= 3 && stall_cnt < 5) begin
                        out_dense_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_dense_ready = 1'b1;
                    end
                end
                2:       out_dense_ready = ($urandom_range(0, 3) != 0);
                default: out_dense_ready = 1'b1;
            endcase
            #1;
            in_masks         = (mi < MW) ? masks[mi] : '0;
            in_masks_valid   = (mi < MW) && in_masks_ready;
            in_encoded       = (ei < enc_words.size()) ? enc_words[ei] : '0;
            in_encoded_valid = (ei < enc_words.size()) && in_encoded_ready;
            if (in_masks_valid) mi++;
            if (in_encoded_valid) ei++;
            hold_pend = out_dense_valid && !out_dense_ready;
            held      = out_dense;
            if (out_dense_valid && out_dense_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (out_dense !== e) begin
                    errors++;
                    $display("FAIL %s dense[%0d]: got %h need %h", name, out_n, out_dense, e);
                end
                checks++;
                if (out_dense_last !== (out_n == WORDS - 1)) begin
                    errors++;
                    $display("FAIL %s last[%0d]: got %b need %b",
                             name, out_n, out_dense_last, (out_n == WORDS - 1));
                end
                if (out_n == 0) first_word = out_dense;
                if (out_n == 1) second_word = out_dense;
                out_n++;
                if (out_dense_last || out_n == WORDS) done = 1'b1;
            end
            @(negedge clk);
            in_masks_valid   = 1'b0;
            in_encoded_valid = 1'b0;
            cyc++;
        end
        out_dense_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got %0d words need %0d", name, out_n, WORDS);
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s frame_end: got busy=%b left=%0d need busy=0 left=0",
                     name, busy, exp_q.size());
        end
        checks++;
        if (overflow_error !== 1'b0 || u_dut.cnt_q !== 6'd0 || ei != enc_words.size()) begin
            errors++;
            $display("FAIL %s residue: got ovf=%b cnt=%0d enc=%0d need ovf=0 cnt=0 enc=%0d",
                     name, overflow_error, u_dut.cnt_q, ei, enc_words.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, in_masks_ready, in_encoded_ready, out_dense_valid,
             out_dense_last, overflow_error} !== 6'b0 || out_dense !== '0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b dense=%h need all 0",
                     {busy, in_masks_ready, in_encoded_ready, out_dense_valid,
                      out_dense_last, overflow_error}, out_dense);
        end
    endtask

    task automatic test_zero_mask();
        vals.delete();
        masks[0] = '0;
        masks[1] = '0;
        run_frame(0, "zero_mask");
        checks++;
        if (first_word !== '0) begin
            errors++;
            $display("FAIL zero_mask word0: got %h need 0", first_word);
        end
    endtask

    task automatic test_sparse_pair();
        vals.delete();
        vals.push_back(8'h11);
        vals.push_back(8'h22);
        masks[0] = 128'h0005;
        masks[1] = '0;
        run_frame(0, "sparse_pair");
        checks++;
        if (first_word !== 128'h220011) begin
            errors++;
            $display("FAIL sparse_pair word0: got %h need %h", first_word, 128'h220011);
        end
    endtask

    task automatic test_straddle();
        logic [127:0] e0, e1;
        vals.delete();
        for (int i = 1; i <= 20; i++) vals.push_back(8'(i));
        masks[0] = {96'b0, 16'h03FF, 16'h03FF};
        masks[1] = '0;
        run_frame(0, "straddle");
        e0 = '0;
        e1 = '0;
        for (int i = 0; i < 10; i++) begin
            e0[8*i +: 8] = 8'(i + 1);
            e1[8*i +: 8] = 8'(i + 11);
        end
        checks++;
        if (first_word !== e0 || second_word !== e1) begin
            errors++;
            $display("FAIL straddle words: got %h %h need %h %h", first_word, second_word, e0, e1);
        end
    endtask

    task automatic test_backpressure();
        random_frame(50);
        run_frame(1, "backpressure");
    endtask

    task automatic test_back_to_back();
        random_frame(100);
        run_frame(0, "b2b_full");
        for (int k = 0; k < 3; k++) begin
            random_frame($urandom_range(0, 100));
            run_frame(2, "b2b_random");
        end
    endtask

    task automatic test_overflow_restart();
        int sent, cyc;
        bit done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start           = 1'b0;
        in_masks        = '0;
        in_masks_valid  = 1'b1;
        out_dense_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (overflow_error !== 1'b1 || out_dense_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b v=%b need ovf=1 v=1",
                     overflow_error, out_dense_valid);
        end
        // Finish the frame cleanly so the sticky flag can be seen in IDLE.
        in_masks_valid  = 1'b0;
        out_dense_ready = 1'b1;
        sent = 1; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            in_masks_valid = (sent < MW) && in_masks_ready;
            if (in_masks_valid) sent++;
            if (out_dense_valid && out_dense_last) done = 1'b1;
            @(negedge clk);
            in_masks_valid = 1'b0;
            cyc++;
        end
        out_dense_ready = 1'b0;
        checks++;
        if (!done || busy !== 1'b0 || overflow_error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got done=%b busy=%b ovf=%b need 1 0 1",
                     done, busy, overflow_error);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (overflow_error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: got ovf=%b busy=%b need 0 1", overflow_error, busy);
        end
        // Load some state, then reset mid-frame.
        in_masks         = '0;
        in_masks_valid   = in_masks_ready;
        in_encoded       = {4{$urandom()}};
        in_encoded_valid = in_encoded_ready;
        @(negedge clk);
        in_masks_valid   = 1'b0;
        in_encoded_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_dense_valid !== 1'b1 || u_dut.cnt_q !== 6'd16) begin
            errors++;
            $display("FAIL midframe_load: got v=%b cnt=%0d need v=1 cnt=16",
                     out_dense_valid, u_dut.cnt_q);
        end
        arst_n_in = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_dense_valid !== 1'b0 || u_dut.cnt_q !== 6'd0 ||
            in_masks_ready !== 1'b0 || overflow_error !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got busy=%b v=%b cnt=%0d mrdy=%b ovf=%b need all 0",
                     busy, out_dense_valid, u_dut.cnt_q, in_masks_ready, overflow_error);
        end
        @(negedge clk);
        arst_n_in = 1'b1;
        random_frame(30);
        run_frame(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_zero_mask();
        test_sparse_pair();
        test_straddle();
        test_backpressure();
        test_back_to_back();
        test_overflow_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sparse_fm_decoder.md
Name: sparse_fm_decoder

Overview:
- Decompresses the zero-value-compressed output feature map produced by top_chip back into dense activation words.
- Consumes two streams from the chip side: the packed nonzero-value stream (encoded) and the bitmask stream (masks).
- Emits one dense MEM_BW-bit word per handshake, 16 elements of IO_DATA_WIDTH bits each.
- Sits in top_system on the chip's output side, ahead of external memory and the bandwidth/checker logic.

Parameters:
- IO_DATA_WIDTH, 8, element width in bits.
- MEM_BW, 128, width of the encoded, mask and dense words.
- FEATURE_MAP_WIDTH, 56, frame width.
- FEATURE_MAP_HEIGHT, 56, frame height.
- OUTPUT_NB_CHANNELS, 64, channels per frame.
- ELEMS_PER_WORD, MEM_BW/IO_DATA_WIDTH (16), derived; number of elements per dense or encoded word.
- FRAME_MASK_WORDS, FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS/MEM_BW (1568), derived; mask words per frame. Overridable for test.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  asynchronous reset, active low.
- start  in  1  single-cycle pulse that begins a frame.
- busy  out  1  high while a frame is in progress.
- in_masks  in  MEM_BW  mask word; bit j set means element j is nonzero.
- in_masks_valid  in  1  mask word valid.
- in_masks_ready  out  1  mask word accepted.
- in_encoded  in  MEM_BW  packed nonzero values; byte k at bits [8k+7:8k].
- in_encoded_valid  in  1  encoded word valid.
- in_encoded_ready  out  1  encoded word accepted.
- out_dense  out  MEM_BW  dense word; element j at bits [8j+7:8j].
- out_dense_valid  out  1  dense word valid.
- out_dense_ready  in  1  downstream accept.
- out_dense_last  out  1  marks the final dense word of the frame.
- overflow_error  out  1  sticky: a valid was presented while the matching ready was low.

Behaviour:
- Reset: all outputs 0, state IDLE, buffers empty, counters 0. Reset mid-frame drops all data.
- A transfer occurs when valid and ready are both high on a rising edge. Output valid/data hold until accepted. Valid never depends combinationally on out_dense_ready.
- States:
  - IDLE: all readies low. On start go to RUN, clear counters and buffers, clear overflow_error.
  - RUN: on the handshake of the dense word with out_dense_last set, go to IDLE.
  - start is ignored outside IDLE.
- Mask register: one MEM_BW-bit register, mask_full flag, and slice index s (0..7). Slice s is mask bits [16s+15:16s].
  - in_masks_ready = RUN and (!mask_full, or the slice-7 dense word is being produced this cycle).
- Encoded buffer: 2*MEM_BW bits, holding 0..32 bytes, with byte count cnt. Bytes are kept in stream order at the low end.
  - in_encoded_ready = RUN and cnt <= 16.
  - An accepted word is appended at position cnt - pop, where pop is the number of bytes consumed in the same cycle.
- Produce condition: mask_full, cnt >= pop, where pop = popcount(slice s), and the output register is empty or being accepted.
  - Element j = slice bit j ? buffer byte[popcount(slice bits below j)] : 0.
  - The buffer shifts down by pop bytes; s increments; at s = 7, mask_full clears.
- Latency: one cycle from the enabling handshake to out_dense_valid. Sustained throughput is 1 dense word/cycle when the inputs keep up.
- All-zero slice: pop = 0, so the word is produced without needing encoded data.
- Frame end: out_dense_last is asserted on dense word 8*FRAME_MASK_WORDS-1. On its handshake the residual buffer bytes (the encoder's padding in the final word) are discarded and cnt = 0.
- The encoder emits exactly ceil(nnz/16) encoded words per frame, so no encoded word is ever pending past frame end.
- overflow_error: set when any in_*_valid is high while its ready is low during RUN. The chip side has no backpressure, so a set flag means data was lost. Cleared only by reset or start.

Decomposition:
- Package sparse_fm_pkg:
  - ELEMS_PER_WORD and SLICES_PER_MASK (8);
  - state enum typedef;
  - popcount16 and prefix-rank functions.
- Sub-module sparse_slice_expand (combinational): inputs 16-bit slice and 16-byte window; outputs dense word and pop.
- The top level holds the FSM, the mask and encoded buffers, the counters and the output register.

Test Plan:
- Zero mask: FRAME_MASK_WORDS=1, in_masks=0, no encoded words -> 8 dense words of 0, last on the 8th, busy low the next cycle, encoded ready never used.
- Slice 0 = 16'h0005, encoded bytes 0x11, 0x22, remaining 14 bytes padding -> dense word 0 has byte0=0x11, byte2=0x22, all other bytes 0.
- Straddle: slices 0 and 1 = 16'h03FF each (20 nonzeros, values 1..20 over two encoded words) -> word 0 bytes 0..9 = 1..10; word 1 bytes 0..9 = 11..20, taking 6 bytes from word A and 4 from word B.
- Backpressure: out_dense_ready low for 5 cycles mid-frame -> out_dense stable and valid held, no element lost or duplicated versus the reference model over a 2-mask-word random frame.
- Overflow and restart: in_masks_valid held high while the mask register is full -> overflow_error=1; a new start clears it; asserting arst_n_in low mid-frame returns busy, out_dense_valid and cnt to 0.
